uart_tx_mmio: RTL and testbench

- Memory-mapped UART transmitter on the CPU core's data-memory port, in parallel with the data RAM.
- Decodes the same store/load strobes and 10-bit word address that the core drives to the RAM.
- Buffers stored bytes in a small FIFO and serialises them 8N1 on a single TX line.
- The top level muxes read_data from this block over RAM data when sel is high.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_fifo.sv | 58 +++++
 rtl/uart_tx_mmio.sv | 155 +++++++++++++++
 tb/tb_uart_tx_mmio.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic [9:0] OFS_TXDATA = 10'd0;
    localparam logic [9:0] OFS_STATUS = 10'd1;

    localparam int unsigned ST_FULL    = 0;
    localparam int unsigned ST_EMPTY   = 1;
    localparam int unsigned ST_BUSY    = 2;
    localparam int unsigned ST_OVF     = 3;
    localparam int unsigned ST_CNT_LSB = 4;

endpackage

// File: rtl/uart_fifo.sv
// Byte-wide synchronous FIFO; head is visible combinationally on dout.
module uart_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS registers, byte FIFO, serialiser FSM.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [9:0]  BASE_ADDR    = 10'h3F0
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [9:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        sel,
    output logic        tx
);

    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned CNTW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_t       state, state_n;
    logic [CW-1:0]   baud_cnt, baud_cnt_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [7:0]      shift, shift_n;
    logic            baud_done;

    logic            hit_data;
    logic            hit_status;
    logic            push;
    logic            pop;
    logic [7:0]      head;
    logic            full;
    logic            empty;
    logic [CNTW-1:0] count;
    logic            overflow;
    logic [31:0]     status;
    logic            unused;

    assign unused = &{1'b0, write_data[31:8]};

    assign hit_data   = (address == BASE_ADDR + OFS_TXDATA);
    assign hit_status = (address == BASE_ADDR + OFS_STATUS);
    assign sel        = hit_data || hit_status;
    assign push       = MemWrite && hit_data;

    uart_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .push  (push),
        .din   (write_data[7:0]),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            overflow <= 1'b0;
        end else if (MemWrite && hit_status && write_data[ST_OVF]) begin
            overflow <= 1'b0;
        end else if (push && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    always_comb begin
        status                       = '0;
        status[ST_FULL]              = full;
        status[ST_EMPTY]             = empty;
        status[ST_BUSY]              = (state != IDLE);
        status[ST_OVF]               = overflow;
        status[ST_CNT_LSB +: CNTW]   = count;
    end

    assign read_data = (MemRead && hit_status) ? status : '0;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
        end
    end

    assign baud_done = (baud_cnt == BAUD_LAST);

    // tx decodes straight from state so an async reset forces the line high at once.
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        pop        = 1'b0;
        tx         = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_n    = head;
                    baud_cnt_n = '0;
                    state_n    = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (baud_done) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    state_n    = DATA;
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                tx = shift[0];
                if (baud_done) begin
                    baud_cnt_n = '0;
                    shift_n    = shift >> 1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_cnt_n = '0;
                    state_n    = IDLE;
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed self-checking bench: one fast-baud instance for framing, one slow-baud instance for overflow.
module tb_uart_tx_mmio;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_mw, a_mr, a_sel, a_tx;
    logic [9:0]  a_addr;
    logic [31:0] a_wd, a_rd;
    logic        b_rst, b_mw, b_mr, b_sel, b_tx;
    logic [9:0]  b_addr;
    logic [31:0] b_wd, b_rd;

    int tests = 0;
    int fails = 0;

    uart_tx_mmio #(
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH  (8),
        .BASE_ADDR   (10'h3F0)
    ) dut_a (
        .CLK        (clk),
        .RSTn       (a_rst),
        .MemWrite   (a_mw),
        .MemRead    (a_mr),
        .address    (a_addr),
        .write_data (a_wd),
        .read_data  (a_rd),
        .sel        (a_sel),
        .tx         (a_tx)
    );

    uart_tx_mmio #(
        .CLKS_PER_BIT(1000),
        .FIFO_DEPTH  (8),
        .BASE_ADDR   (10'h3F0)
    ) dut_b (
        .CLK        (clk),
        .RSTn       (b_rst),
        .MemWrite   (b_mw),
        .MemRead    (b_mr),
        .address    (b_addr),
        .write_data (b_wd),
        .read_data  (b_rd),
        .sel        (b_sel),
        .tx         (b_tx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bus(input bit which, input logic w, input logic r,
                       input logic [9:0] ad, input logic [31:0] d);
        if (!which) begin
            a_mw = w; a_mr = r; a_addr = ad; a_wd = d;
        end else begin
            b_mw = w; b_mr = r; b_addr = ad; b_wd = d;
        end
    endtask

    task automatic rd_status(input bit which, output logic [31:0] v);
        bus(which, 1'b0, 1'b1, 10'h3F1, 32'h0);
        #1;
        v = which ? b_rd : a_rd;
        bus(which, 1'b0, 1'b0, 10'h000, 32'h0);
    endtask

    task automatic store_a(input logic [31:0] d);
        bus(1'b0, 1'b1, 1'b0, 10'h3F0, d);
        tick();
        bus(1'b0, 1'b0, 1'b0, 10'h000, 32'h0);
    endtask

    // Called on the first frame cycle; returns on the cycle after the stop bit.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic [7:0] dec;
        logic       e;
        dec = '0;
        for (int i = 0; i < 40; i++) begin
            if (i < 4)       e = 1'b0;
            else if (i < 36) e = b[(i - 4) / 4];
            else             e = 1'b1;
            check($sformatf("%s_c%0d", tag, i), {31'b0, a_tx}, {31'b0, e});
            if (i >= 4 && i < 36 && (i % 4) == 2) dec[(i - 4) / 4] = a_tx;
            tick();
        end
        check({tag, "_byte"}, {24'b0, dec}, {24'b0, b});
    endtask

    initial begin
        logic [31:0] v;
        bit          found;

        a_rst = 1'b0; b_rst = 1'b0;
        bus(1'b0, 1'b0, 1'b0, 10'h000, 32'h0);
        bus(1'b1, 1'b0, 1'b0, 10'h000, 32'h0);
        tick();
        check("rst_tx", {31'b0, a_tx}, 32'h1);
        bus(1'b0, 1'b0, 1'b0, 10'h3F1, 32'h0);
        #1;
        check("rst_rd_noread", a_rd, 32'h0);
        rd_status(1'b0, v);
        check("rst_status", v, 32'h0000_0002);
        tick();
        a_rst = 1'b1; b_rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("idle_tx%0d", i), {31'b0, a_tx}, 32'h1);
        end
        rd_status(1'b0, v);
        check("idle_status", v, 32'h0000_0002);

        bus(1'b0, 1'b0, 1'b1, 10'h3F0, 32'h0);
        #1;
        check("txdata_sel", {31'b0, a_sel}, 32'h1);
        check("txdata_rd", a_rd, 32'h0);
        bus(1'b0, 1'b0, 1'b0, 10'h000, 32'h0);

        // Single frame of 0xA5 with upper data bits set
        tick();
        store_a(32'hFFFF_FFA5);
        check("a5_tx_pre", {31'b0, a_tx}, 32'h1);
        rd_status(1'b0, v);
        check("a5_count1", v, 32'h0000_0010);
        tick();
        check_frame(8'hA5, "a5");
        check("a5_idle_tx", {31'b0, a_tx}, 32'h1);
        rd_status(1'b0, v);
        check("a5_status_end", v, 32'h0000_0002);
        tick();

        // Back-to-back frames with a single idle cycle between them
        store_a(32'h01);
        store_a(32'h80);
        check_frame(8'h01, "f01");
        check("gap_tx", {31'b0, a_tx}, 32'h1);
        tick();
        check_frame(8'h80, "f80");
        check("f80_idle_tx", {31'b0, a_tx}, 32'h1);
        rd_status(1'b0, v);
        check("f80_status", v, 32'h0000_0002);
        tick();

        // Fill FIFO, then push exactly on the IDLE pop edge
        for (int i = 0; i < 9; i++) begin
            bus(1'b0, 1'b1, 1'b0, 10'h3F0, 32'h10 + i);
            tick();
        end
        bus(1'b0, 1'b0, 1'b0, 10'h000, 32'h0);
        rd_status(1'b0, v);
        check("fill_status", v, 32'h0000_0085);
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            rd_status(1'b0, v);
            if (v[2] == 1'b0) begin
                found = 1'b1;
                bus(1'b0, 1'b1, 1'b0, 10'h3F0, 32'h99);
                tick();
                bus(1'b0, 1'b0, 1'b0, 10'h000, 32'h0);
                break;
            end
            tick();
        end
        check("pop_edge_found", {31'b0, found}, 32'h1);
        rd_status(1'b0, v);
        check("pushpop_status", v, 32'h0000_0085);

        // Frame of 0x11 now running; index 9 is data bit1 = 0
        for (int i = 0; i < 9; i++) tick();
        check("mid_tx_low", {31'b0, a_tx}, 32'h0);
        #2;
        a_rst = 1'b0;
        #1;
        check("async_rst_tx", {31'b0, a_tx}, 32'h1);
        tick();
        a_rst = 1'b1;
        rd_status(1'b0, v);
        check("post_rst_status", v, 32'h0000_0002);
        for (int i = 0; i < 50; i++) begin
            tick();
            check($sformatf("post_rst_tx%0d", i), {31'b0, a_tx}, 32'h1);
        end

        bus(1'b0, 1'b0, 1'b1, 10'h3EF, 32'h0);
        #1;
        check("miss_sel", {31'b0, a_sel}, 32'h0);
        check("miss_rd", a_rd, 32'h0);
        bus(1'b0, 1'b0, 1'b0, 10'h000, 32'h0);

        // Overflow on the slow instance
        tick();
        for (int i = 0; i < 10; i++) begin
            bus(1'b1, 1'b1, 1'b0, 10'h3F0, 32'h20 + i);
            tick();
        end
        bus(1'b1, 1'b0, 1'b0, 10'h000, 32'h0);
        rd_status(1'b1, v);
        check("ovf_status", v, 32'h0000_008D);
        tick();
        bus(1'b1, 1'b1, 1'b1, 10'h3F1, 32'h8);
        #1;
        check("rw_pre_edge", b_rd, 32'h0000_008D);
        tick();
        bus(1'b1, 1'b0, 1'b0, 10'h000, 32'h0);
        rd_status(1'b1, v);
        check("ovf_cleared", v, 32'h0000_0085);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
